udp_tx_fifo_rd_ctrl: RTL and testbench
======================================

UDP_TX_FIFO_RD_CTRL -- requirements
Module: udp_tx_fifo_rd_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, is the RAM address width; legal range 4-10; depth is 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, is the word width; legal range 1-256.
REQ-003 Parameter AFULL_TH, default 2**ADDR_WIDTH-2, is the occupancy at or above which afull asserts.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 clr  in  1  synchronous flush, active-high.
REQ-007 in_valid, in_data, in_ready  in, in, out  1, DATA_WIDTH, 1  upstream push handshake.
REQ-008 out_valid, out_data, out_ready  out, out, in  1, DATA_WIDTH, 1  downstream first-word-fall-through (FWFT) stream.
REQ-009 ram_wr_en, ram_wr_addr, ram_wr_data  out, out, out  1, ADDR_WIDTH, DATA_WIDTH  write port to the external distributed SDPRAM.
REQ-010 ram_rd_addr, ram_rd_data  out, in  ADDR_WIDTH, DATA_WIDTH  read port to the SDPRAM; the SDPRAM is instantiated with OUT_REG=0, so its read is combinational.
REQ-011 count, full, empty, afull, ovf  out  ADDR_WIDTH+1, 1, 1, 1, 1  status outputs.

Function
REQ-012 Write pointer wp and read pointer rp SHALL each be ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the RAM, and the MSB is a wrap bit.
REQ-013 count SHALL equal wp-rp modulo 2**(ADDR_WIDTH+1); it covers words held in RAM only, excluding the output register.
REQ-014 full SHALL equal (count == 2**ADDR_WIDTH); empty SHALL equal (count == 0); afull SHALL equal (count >= AFULL_TH); all three are combinational from registered pointers.
REQ-015 in_ready SHALL equal !full && !clr.
REQ-016 A push SHALL occur when in_valid && in_ready: ram_wr_en=1, ram_wr_addr=wp[ADDR_WIDTH-1:0], ram_wr_data=in_data, and wp increments at that edge.
REQ-017 ram_wr_en SHALL be 0 whenever no push occurs.
REQ-018 ram_rd_addr SHALL equal rp[ADDR_WIDTH-1:0] at all times.
REQ-019 The output register (out_valid, out_data) SHALL load ram_rd_data, and rp SHALL increment, at any edge where !empty && (!out_valid || out_ready) && !clr.
REQ-020 At an edge where out_valid && out_ready and the load condition is false, out_valid SHALL go to 0.
REQ-021 out_data SHALL be stable while out_valid && !out_ready.
REQ-022 Latency: a word pushed at edge E into an empty FIFO with out_valid=0 SHALL appear with out_valid=1 after edge E+1.
REQ-023 Push and load in the same cycle SHALL both take effect; count is then unchanged.
REQ-024 Sustained throughput with out_ready=1 SHALL be one word per cycle.
REQ-025 Pointers SHALL wrap naturally modulo 2**(ADDR_WIDTH+1); data order is preserved across wrap.
REQ-026 in_valid && !in_ready SHALL set sticky ovf; the word is dropped and wp is unchanged.
REQ-027 ovf SHALL clear only on clr or reset.
REQ-028 clr SHALL set wp=rp=0, out_valid=0, and ovf=0 at the next edge.
REQ-029 clr has priority over a simultaneous push or load; any RAM contents are ignored.

Reset
REQ-030 On rst_n=0 the block SHALL immediately set wp=0, rp=0, out_valid=0, out_data=0 and ovf=0.
REQ-031 During reset count=0, empty=1, full=0, afull=0, in_ready=1 and ram_wr_en=0.
REQ-032 Reset asserted mid-transfer SHALL discard all contents without waiting for a clock edge.
REQ-033 After deassertion, the first push SHALL be accepted on the first clock edge.

Verification
REQ-034 Latency check: ADDR_WIDTH=4, out_ready=0, push 0x11 -> out_valid=1 and out_data=0x11 one cycle later; count=0 and empty=1.
REQ-035 Fill: out_ready=0, push 17 words 0x00..0x10 -> output register holds 0x00, RAM holds 0x01..0x10, count=16, full=1, in_ready=0; afull first asserts at count=14.
REQ-036 Overflow: while full, in_valid=1 with 0xAA for 1 cycle -> ovf=1 and stays 1; 0xAA never appears on out_data; a subsequent clr gives ovf=0, empty=1, out_valid=0.
REQ-037 Streaming wrap: in_valid=1 and out_ready=1 for 40 cycles with incrementing data -> out_data sequence is identical and contiguous; count stays 0 or 1; no ovf.
REQ-038 Backpressure: random out_ready at 50% -> out_data holds while stalled; no words lost or duplicated over 1000 words.
REQ-039 Reset mid-operation: with count=9 and out_valid=1, pulse rst_n low between edges -> outputs reset immediately; after release, pushing 0x5A yields 0x5A as the first output.

Source files
------------

// File: rtl/udp_tx_fifo_rd_ctrl.sv
// FIFO control around an external combinational-read SDPRAM with a registered
// first-word-fall-through output stage. Pointers carry a wrap bit for full/empty.
module udp_tx_fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int AFULL_TH   = 2**ADDR_WIDTH - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  ovf
);

   localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AFULL_V = (ADDR_WIDTH+1)'(AFULL_TH);

   logic [ADDR_WIDTH:0] wp;
   logic [ADDR_WIDTH:0] rp;
   logic                push;
   logic                load;

   assign count    = wp - rp;
   assign full     = (count == DEPTH);
   assign empty    = (count == '0);
   assign afull    = (count >= AFULL_V);
   assign in_ready = !full && !clr;

   // rst_n gates the write strobe so nothing reaches the RAM while reset is held
   assign push        = in_valid && in_ready && rst_n;
   assign ram_wr_en   = push;
   assign ram_wr_addr = wp[ADDR_WIDTH-1:0];
   assign ram_wr_data = in_data;
   assign ram_rd_addr = rp[ADDR_WIDTH-1:0];

   assign load = !empty && (!out_valid || out_ready) && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         ovf       <= 1'b0;
      end else if (clr) begin
         wp        <= '0;
         rp        <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (push)
            wp <= wp + 1'b1;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= ram_rd_data;
            rp        <= rp + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (in_valid && !in_ready)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_udp_tx_fifo_rd_ctrl.sv
// Bench for udp_tx_fifo_rd_ctrl: table vectors, hand sequences and random
// traffic checked against a queue-based model of FIFO plus output register.
module tb_udp_tx_fifo_rd_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_wr_data;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic [AW:0]   count;
   logic          full, empty, afull, ovf;

   udp_tx_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .count(count), .full(full), .empty(empty), .afull(afull), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // distributed SDPRAM with combinational read
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   assign ram_rd_data = mem[ram_rd_addr];

   int vectors = 0;
   int miscompares = 0;

   // reference model: words held in RAM, plus the output register
   logic [DW-1:0] mq [$];
   logic          m_ov  = 1'b0;
   logic [DW-1:0] m_od  = '0;
   logic          m_ovf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_state();
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full",  32'(full),  32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("afull", 32'(afull), 32'(mq.size() >= DEPTH-2));
      chk("ovf",   32'(ovf),   32'(m_ovf));
   endtask

   task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic cl);
      logic rdy, ld;
      in_valid = iv; in_data = id; out_ready = ordy; clr = cl;
      #1;
      rdy = (mq.size() != DEPTH) && !cl;
      chk("in_ready",  32'(in_ready),  32'(rdy));
      chk("ram_wr_en", 32'(ram_wr_en), 32'(iv && rdy));
      @(posedge clk);
      if (cl) begin
         mq.delete(); m_ov = 1'b0; m_ovf = 1'b0;
      end else begin
         ld = (mq.size() > 0) && (!m_ov || ordy);
         if (iv && !rdy) m_ovf = 1'b1;
         if (ld) begin m_od = mq.pop_front(); m_ov = 1'b1; end
         else if (ordy) m_ov = 1'b0;
         if (iv && rdy) mq.push_back(id);
      end
      #1;
      chk_state();
   endtask

   typedef struct {
      logic          iv;
      logic [DW-1:0] id;
      logic          ordy;
      logic          cl;
      logic          ov;
      logic [DW-1:0] od;
      logic [AW:0]   cnt;
      logic          emp;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic       afull_seen;
      logic [DW-1:0] nxt;
      int         got;
      int         cyc;

      tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
      tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 5'd0, 1'b1};
      tbl[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0};
      tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0};
      tbl[6]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 5'd0, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
      tbl[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
      tbl[10] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66, 5'd0, 1'b1};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data),  0);
      chk("rst_count",     32'(count),     0);
      chk("rst_empty",     32'(empty),     1);
      chk("rst_full",      32'(full),      0);
      chk("rst_in_ready",  32'(in_ready),  1);
      #9 rst_n = 1'b1;

      // table vectors, including the single-word latency case
      for (int unsigned i = 0; i < 13; i++) begin
         cycle(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].cl);
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      end

      // fill: 17 words with output stalled, afull first seen at 14
      afull_seen = 1'b0;
      for (int unsigned i = 0; i < 17; i++) begin
         cycle(1'b1, DW'(i), 1'b0, 1'b0);
         if (afull && !afull_seen) begin
            afull_seen = 1'b1;
            chk("afull_first_count", 32'(count), 14);
         end
      end
      chk("fill_afull_seen", 32'(afull_seen), 1);
      chk("fill_count",    32'(count),    16);
      chk("fill_full",     32'(full),     1);
      chk("fill_in_ready", 32'(in_ready), 0);
      chk("fill_out_data", 32'(out_data), 8'h00);

      // overflow while full: word dropped, ovf sticky
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_set", 32'(ovf), 1);
      for (int unsigned i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      chk("ovf_sticky", 32'(ovf), 1);
      nxt = 8'h00;
      for (int unsigned i = 0; i < 18; i++) begin
         if (out_valid) begin
            chk("drain_seq", 32'(out_data), 32'(nxt));
            nxt++;
         end
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      chk("drain_all_words", 32'(nxt), 17);
      chk("drain_ovf_held", 32'(ovf), 1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("clr_ovf", 32'(ovf), 0);
      chk("clr_empty", 32'(empty), 1);
      chk("clr_out_valid", 32'(out_valid), 0);

      // streaming across pointer wrap
      for (int unsigned i = 0; i < 40; i++) begin
         cycle(1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
         if (count > 1) chk("stream_count_le1", 32'(count), 1);
      end
      chk("stream_ovf", 32'(ovf), 0);
      chk("stream_last", 32'(out_data), 32'(8'h80 + 38));
      for (int unsigned i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // random traffic with 50% backpressure
      got = 0; cyc = 0;
      while (got < 1000 && cyc < 20000) begin
         if (out_valid && out_ready) got++;
         cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, DW'($urandom),
               $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 1'b0);
         cyc++;
      end
      chk("random_words_done", 32'(got >= 1000), 1);

      // asynchronous reset mid-operation
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int unsigned i = 0; i < 10; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(count), 9);
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      in_valid = 1'b1; in_data = 8'h77;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_data",  32'(out_data),  0);
      chk("arst_count",     32'(count),     0);
      chk("arst_empty",     32'(empty),     1);
      chk("arst_full",      32'(full),      0);
      chk("arst_afull",     32'(afull),     0);
      chk("arst_ovf",       32'(ovf),       0);
      chk("arst_in_ready",  32'(in_ready),  1);
      chk("arst_ram_wr_en", 32'(ram_wr_en), 0);
      #1;
      rst_n = 1'b1; in_valid = 1'b0;
      mq.delete(); m_ov = 1'b0; m_od = '0; m_ovf = 1'b0;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("post_rst_first_push", 32'(count), 1);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("post_rst_out", 32'(out_data), 8'h5A);
      chk("post_rst_valid", 32'(out_valid), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
